alu_reservation_station: RTL and testbench

- Reservation station feeding the ALU in the Tomasulo out-of-order core.
- Holds dispatched ALU/branch/jump µops and captures missing operands from the ALU and LSB result broadcasts (CDB).
- Issues at most one ready µop per cycle to the ALU through the RS_* bus: RS_flag, RS_op, RS_Vj, RS_Vk, RS_idx, RS_imm, RS_PC.

---
 rtl/alu_reservation_station_pkg.sv | 25 ++
 rtl/alu_reservation_station_if.sv | 39 +++
 rtl/alu_reservation_station_rs_prio_enc.sv | 20 ++
 rtl/alu_reservation_station.sv | 144 ++++++++++++++
 tb/tb_alu_reservation_station.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared constants for the ALU reservation station: ROB tag width, entry count, opcode encodings.
package alu_reservation_station_pkg;

  localparam int   ROB_INDEX_W = 4;
  localparam int   RS_ENTRIES  = 16;
  localparam logic TRUE        = 1'b1;
  localparam logic FALSE       = 1'b0;

  typedef enum logic [5:0] {
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_ADD   = 6'd10,
    OP_SUB   = 6'd11,
    OP_OR    = 6'd12,
    OP_AND   = 6'd13
  } rs_op_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and issue bus of the ALU reservation station.
interface alu_reservation_station_if #(
  parameter int ROB_W = 4
);
  logic             dsp_flag;
  logic [5:0]       dsp_op;
  logic [31:0]      dsp_Vj, dsp_Vk;
  logic             dsp_Qj_v, dsp_Qk_v;
  logic [ROB_W-1:0] dsp_Qj, dsp_Qk, dsp_idx;
  logic [31:0]      dsp_imm, dsp_PC;

  logic             ALU_flag;
  logic [ROB_W-1:0] ALU_ROB_idx;
  logic [31:0]      ALU_val;
  logic             LSB_flag;
  logic [ROB_W-1:0] LSB_ROB_idx;
  logic [31:0]      LSB_val;

  logic             RS_full;
  logic             RS_flag;
  logic [5:0]       RS_op;
  logic [31:0]      RS_Vj, RS_Vk;
  logic [ROB_W-1:0] RS_idx;
  logic [31:0]      RS_imm, RS_PC;

  modport master (
    output dsp_flag, dsp_op, dsp_Vj, dsp_Vk, dsp_Qj_v, dsp_Qk_v, dsp_Qj, dsp_Qk,
           dsp_idx, dsp_imm, dsp_PC,
    output ALU_flag, ALU_ROB_idx, ALU_val, LSB_flag, LSB_ROB_idx, LSB_val,
    input  RS_full, RS_flag, RS_op, RS_Vj, RS_Vk, RS_idx, RS_imm, RS_PC
  );

  modport slave (
    input  dsp_flag, dsp_op, dsp_Vj, dsp_Vk, dsp_Qj_v, dsp_Qk_v, dsp_Qj, dsp_Qk,
           dsp_idx, dsp_imm, dsp_PC,
    input  ALU_flag, ALU_ROB_idx, ALU_val, LSB_flag, LSB_ROB_idx, LSB_val,
    output RS_full, RS_flag, RS_op, RS_Vj, RS_Vk, RS_idx, RS_imm, RS_PC
  );
endinterface

// File: rtl/alu_reservation_station_rs_prio_enc.sv
// Lowest-set-bit encoder: vld_o when any request is set, idx_o is the lowest set position.
module rs_prio_enc #(
  parameter  int N = 16,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        vld_o = 1'b1;
        idx_o = W'(i);
      end
    end
  end
endmodule

// File: rtl/alu_reservation_station.sv
// Tomasulo ALU reservation station: holds µops, snoops ALU/LSB CDB, issues lowest ready entry.
// Optional RS_CDB_BYPASS_EN: an entry whose last operands arrive on the CDB this cycle issues at once.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_ENTRIES,
  parameter int ROB_W   = ROB_INDEX_W
) (
  input logic                      clk,
  input logic                      rst,
  input logic                      rdy,
  input logic                      roll,
  alu_reservation_station_if.slave bus
);
  localparam int IW = idx_w(RS_SIZE);

  typedef struct packed {
    logic [5:0]       op;
    logic [31:0]      vj, vk;
    logic             qjv, qkv;
    logic [ROB_W-1:0] qj, qk, idx;
    logic [31:0]      imm, pc;
  } ent_t;

  typedef struct packed {
    logic [5:0]       op;
    logic [31:0]      vj, vk;
    logic [ROB_W-1:0] idx;
    logic [31:0]      imm, pc;
  } iss_t;

  logic [RS_SIZE-1:0] busy_q, busy_d, ready;
  ent_t               ent_q [RS_SIZE];
  ent_t               ent_d [RS_SIZE];
  ent_t               ent_w [RS_SIZE];
  ent_t               dsp_w;
  logic               free_v, iss_v, full;
  logic [IW-1:0]      free_idx, iss_idx;
  logic               flag_q, flag_d;
  iss_t               out_q, out_d;

  logic             alu_f, lsb_f;
  logic [ROB_W-1:0] alu_tag, lsb_tag;
  logic [31:0]      alu_val, lsb_val;
  assign alu_f   = bus.ALU_flag;
  assign alu_tag = bus.ALU_ROB_idx;
  assign alu_val = bus.ALU_val;
  assign lsb_f   = bus.LSB_flag;
  assign lsb_tag = bus.LSB_ROB_idx;
  assign lsb_val = bus.LSB_val;

  // Returns {still_pending, value}; the ALU broadcast wins over LSB on a tag tie.
  function automatic logic [32:0] snoop(input logic qv, input logic [ROB_W-1:0] q,
                                        input logic [31:0] v);
    if (qv && alu_f && q == alu_tag) return {1'b0, alu_val};
    if (qv && lsb_f && q == lsb_tag) return {1'b0, lsb_val};
    return {qv, v};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_w[i] = ent_q[i];
      {ent_w[i].qjv, ent_w[i].vj} = snoop(ent_q[i].qjv, ent_q[i].qj, ent_q[i].vj);
      {ent_w[i].qkv, ent_w[i].vk} = snoop(ent_q[i].qkv, ent_q[i].qk, ent_q[i].vk);
`ifdef RS_CDB_BYPASS_EN
      ready[i] = busy_q[i] & ~ent_w[i].qjv & ~ent_w[i].qkv;
`else
      ready[i] = busy_q[i] & ~ent_q[i].qjv & ~ent_q[i].qkv;
`endif
    end
  end

  always_comb begin
    dsp_w     = '0;
    dsp_w.op  = bus.dsp_op;
    dsp_w.qj  = bus.dsp_Qj;
    dsp_w.qk  = bus.dsp_Qk;
    dsp_w.idx = bus.dsp_idx;
    dsp_w.imm = bus.dsp_imm;
    dsp_w.pc  = bus.dsp_PC;
    {dsp_w.qjv, dsp_w.vj} = snoop(bus.dsp_Qj_v, bus.dsp_Qj, bus.dsp_Vj);
    {dsp_w.qkv, dsp_w.vk} = snoop(bus.dsp_Qk_v, bus.dsp_Qk, bus.dsp_Vk);
  end

  rs_prio_enc #(.N(RS_SIZE)) u_free_sel (.req_i(~busy_q), .vld_o(free_v), .idx_o(free_idx));
  rs_prio_enc #(.N(RS_SIZE)) u_iss_sel  (.req_i(ready),   .vld_o(iss_v),  .idx_o(iss_idx));

  assign full = &busy_q;

  // The free slot is taken from pre-edge busy bits, so it never collides with the issued slot.
  always_comb begin
    busy_d = busy_q;
    ent_d  = ent_w;
    flag_d = 1'b0;
    out_d  = out_q;
    if (roll) begin
      busy_d = '0;
    end else begin
      if (iss_v) begin
        busy_d[iss_idx] = 1'b0;
        flag_d          = 1'b1;
        out_d.op        = ent_w[iss_idx].op;
        out_d.vj        = ent_w[iss_idx].vj;
        out_d.vk        = ent_w[iss_idx].vk;
        out_d.idx       = ent_w[iss_idx].idx;
        out_d.imm       = ent_w[iss_idx].imm;
        out_d.pc        = ent_w[iss_idx].pc;
      end
      if (bus.dsp_flag && free_v) begin
        busy_d[free_idx] = 1'b1;
        ent_d[free_idx]  = dsp_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      flag_q <= 1'b0;
      out_q  <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      flag_q <= flag_d;
      out_q  <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) ent_q <= ent_d;
  end

  assign bus.RS_full = full;
  assign bus.RS_flag = flag_q;
  assign bus.RS_op   = out_q.op;
  assign bus.RS_Vj   = out_q.vj;
  assign bus.RS_Vk   = out_q.vk;
  assign bus.RS_idx  = out_q.idx;
  assign bus.RS_imm  = out_q.imm;
  assign bus.RS_PC   = out_q.pc;

  // Dispatching into a full station drops the µop; that is a dispatcher bug.
  assert property (@(posedge clk) disable iff (rst) !(rdy && !roll && bus.dsp_flag && full));

endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: directed table, corner sequences, random vs reference model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int N = 16;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rdy, roll;

  alu_reservation_station_if #(.ROB_W(4)) bus ();

  alu_reservation_station #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .roll(roll),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    bit          pj, pk;
    logic [3:0]  tj, tk, idx;
  } ment_t;

  ment_t       m [N];
  bit          e_flag;
  logic [5:0]  e_op;
  logic [31:0] e_vj, e_vk, e_imm, e_pc;
  logic [3:0]  e_idx;

  function automatic bit cdb(input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    if (bus.ALU_flag && bus.ALU_ROB_idx == tag) begin val = bus.ALU_val; return 1'b1; end
    if (bus.LSB_flag && bus.LSB_ROB_idx == tag) begin val = bus.LSB_val; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m[i].busy);
    return c;
  endfunction

  // Reference: one clock edge of the station's behaviour, given inputs currently on the bus.
  task automatic model_step();
    int sel, fr;
    logic [31:0] v;
    bit rj, rk;
    if (rst) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      e_flag = 0; e_op = '0; e_vj = '0; e_vk = '0; e_idx = '0; e_imm = '0; e_pc = '0;
      return;
    end
    if (!rdy) return;
    if (roll) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      e_flag = 0;
      return;
    end
    sel = -1;
    fr  = -1;
    for (int i = 0; i < N; i++) begin
      if (!m[i].busy && fr < 0) fr = i;
      if (m[i].busy && sel < 0) begin
        rj = !m[i].pj || (BYP && cdb(m[i].tj, v));
        rk = !m[i].pk || (BYP && cdb(m[i].tk, v));
        if (rj && rk) sel = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && m[i].pj && cdb(m[i].tj, v)) begin m[i].vj = v; m[i].pj = 0; end
      if (m[i].busy && m[i].pk && cdb(m[i].tk, v)) begin m[i].vk = v; m[i].pk = 0; end
    end
    e_flag = (sel >= 0);
    if (sel >= 0) begin
      e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
      e_idx = m[sel].idx; e_imm = m[sel].imm; e_pc = m[sel].pc;
      m[sel].busy = 1'b0;
    end
    if (bus.dsp_flag && fr >= 0) begin
      m[fr].busy = 1'b1;
      m[fr].op = bus.dsp_op; m[fr].idx = bus.dsp_idx; m[fr].imm = bus.dsp_imm; m[fr].pc = bus.dsp_PC;
      m[fr].tj = bus.dsp_Qj; m[fr].tk = bus.dsp_Qk;
      m[fr].vj = bus.dsp_Vj; m[fr].pj = bus.dsp_Qj_v;
      m[fr].vk = bus.dsp_Vk; m[fr].pk = bus.dsp_Qk_v;
      if (m[fr].pj && cdb(m[fr].tj, v)) begin m[fr].vj = v; m[fr].pj = 0; end
      if (m[fr].pk && cdb(m[fr].tk, v)) begin m[fr].vk = v; m[fr].pk = 0; end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("RS_flag", 32'(bus.RS_flag), 32'(e_flag));
    chk("RS_op",   32'(bus.RS_op),   32'(e_op));
    chk("RS_Vj",   bus.RS_Vj,        e_vj);
    chk("RS_Vk",   bus.RS_Vk,        e_vk);
    chk("RS_idx",  32'(bus.RS_idx),  32'(e_idx));
    chk("RS_imm",  bus.RS_imm,       e_imm);
    chk("RS_PC",   bus.RS_PC,        e_pc);
    chk("RS_full", 32'(bus.RS_full), 32'(m_count() == N));
  endtask

  task automatic clr_in();
    bus.dsp_flag = 0; bus.dsp_op = '0; bus.dsp_Vj = '0; bus.dsp_Vk = '0;
    bus.dsp_Qj_v = 0; bus.dsp_Qk_v = 0; bus.dsp_Qj = '0; bus.dsp_Qk = '0;
    bus.dsp_idx = '0; bus.dsp_imm = '0; bus.dsp_PC = '0;
    bus.ALU_flag = 0; bus.ALU_ROB_idx = '0; bus.ALU_val = '0;
    bus.LSB_flag = 0; bus.LSB_ROB_idx = '0; bus.LSB_val = '0;
  endtask

  task automatic put_dsp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input bit pj, input logic [3:0] tj, input bit pk, input logic [3:0] tk,
                         input logic [3:0] idx);
    bus.dsp_flag = 1; bus.dsp_op = op; bus.dsp_Vj = vj; bus.dsp_Vk = vk;
    bus.dsp_Qj_v = pj; bus.dsp_Qj = tj; bus.dsp_Qk_v = pk; bus.dsp_Qk = tk;
    bus.dsp_idx = idx; bus.dsp_imm = $urandom; bus.dsp_PC = $urandom;
  endtask

  typedef struct {
    bit          dsp;
    logic [5:0]  op;
    logic [31:0] vj, vk;
    bit          pk;
    logic [3:0]  tk, idx;
    bit          lsb;
    logic [3:0]  ltag;
    logic [31:0] lval;
    bit          xf;
    logic [5:0]  xop;
    logic [31:0] xvj, xvk;
    logic [3:0]  xidx;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1, OP_ADD, 5,  7, 0, 0, 3, 0, 0, 0,        0,    0,      0,  0,        0};
    tbl[1]  = '{0, 0,      0,  0, 0, 0, 0, 0, 0, 0,        1,    OP_ADD, 5,  7,        3};
    tbl[2]  = '{0, 0,      0,  0, 0, 0, 0, 0, 0, 0,        0,    0,      0,  0,        0};
    tbl[3]  = '{1, OP_SUB, 10, 0, 1, 4, 6, 1, 4, 32'hDEAD, 0,    0,      0,  0,        0};
    tbl[4]  = '{0, 0,      0,  0, 0, 0, 0, 0, 0, 0,        1,    OP_SUB, 10, 32'hDEAD, 6};
    tbl[5]  = '{0, 0,      0,  0, 0, 0, 0, 0, 0, 0,        0,    0,      0,  0,        0};
    tbl[6]  = '{1, OP_OR,  1,  0, 1, 8, 2, 1, 7, 32'h55,   0,    0,      0,  0,        0};
    tbl[7]  = '{0, 0,      0,  0, 0, 0, 0, 0, 0, 0,        0,    0,      0,  0,        0};
    tbl[8]  = '{0, 0,      0,  0, 0, 0, 0, 1, 8, 32'h77,   BYP,  OP_OR,  1,  32'h77,   2};
    tbl[9]  = '{0, 0,      0,  0, 0, 0, 0, 0, 0, 0,        !BYP, OP_OR,  1,  32'h77,   2};
    tbl[10] = '{0, 0,      0,  0, 0, 0, 0, 0, 0, 0,        0,    0,      0,  0,        0};

    clr_in();
    rst = 1; rdy = 1; roll = 0;
    tick(); tick();
    rst = 0;
    chk("rst_flag", 32'(bus.RS_flag), 0);
    chk("rst_full", 32'(bus.RS_full), 0);
    chk("rst_op",   32'(bus.RS_op),   0);

    for (int r = 0; r < 11; r++) begin
      clr_in();
      if (tbl[r].dsp) put_dsp(tbl[r].op, tbl[r].vj, tbl[r].vk, 0, 0, tbl[r].pk, tbl[r].tk, tbl[r].idx);
      if (tbl[r].lsb) begin
        bus.LSB_flag = 1; bus.LSB_ROB_idx = tbl[r].ltag; bus.LSB_val = tbl[r].lval;
      end
      tick();
      chk("tbl_flag", 32'(bus.RS_flag), 32'(tbl[r].xf));
      if (tbl[r].xf) begin
        chk("tbl_op",  32'(bus.RS_op),  32'(tbl[r].xop));
        chk("tbl_vj",  bus.RS_Vj,       tbl[r].xvj);
        chk("tbl_vk",  bus.RS_Vk,       tbl[r].xvk);
        chk("tbl_idx", 32'(bus.RS_idx), 32'(tbl[r].xidx));
      end
    end

    // SUB waiting on tag 9; ALU and LSB broadcast tag 9 together, ALU value must win.
    clr_in(); put_dsp(OP_SUB, 0, 3, 1, 9, 0, 0, 5); tick();
    for (int k = 0; k < 3; k++) begin
      clr_in(); tick();
      chk("sub_wait", 32'(bus.RS_flag), 0);
    end
    clr_in();
    bus.ALU_flag = 1; bus.ALU_ROB_idx = 9; bus.ALU_val = 32'h100;
    bus.LSB_flag = 1; bus.LSB_ROB_idx = 9; bus.LSB_val = 32'hBAD;
    tick();
    chk("sub_byp_flag", 32'(bus.RS_flag), 32'(BYP));
    clr_in();
    if (!BYP) tick();
    chk("sub_flag", 32'(bus.RS_flag), 1);
    chk("sub_vj",   bus.RS_Vj, 32'h100);
    chk("sub_vk",   bus.RS_Vk, 32'h3);
    chk("sub_idx",  32'(bus.RS_idx), 5);
    tick();

    // Fill all entries waiting on tag 2, then release them with one broadcast.
    for (int k = 0; k < N; k++) begin
      clr_in(); put_dsp(OP_ADD, 0, 32'(k), 1, 2, 0, 0, 4'(k)); tick();
    end
    clr_in();
    chk("fill_full", 32'(bus.RS_full), 1);
    bus.ALU_flag = 1; bus.ALU_ROB_idx = 2; bus.ALU_val = 32'h22;
    tick();
    clr_in();
    if (!BYP) tick();
    for (int k = 0; k < N; k++) begin
      chk("fill_flag", 32'(bus.RS_flag), 1);
      chk("fill_idx",  32'(bus.RS_idx),  32'(k));
      chk("fill_vj",   bus.RS_Vj,        32'h22);
      chk("fill_full_drop", 32'(bus.RS_full), 0);
      tick();
    end
    chk("fill_end", 32'(bus.RS_flag), 0);

    // Roll with five waiting entries and a same-cycle dispatch.
    for (int k = 0; k < 5; k++) begin
      clr_in(); put_dsp(OP_AND, 1, 2, 1, 11, 0, 0, 4'(k)); tick();
    end
    clr_in(); put_dsp(OP_AND, 1, 2, 0, 0, 0, 0, 4'd7); roll = 1; tick();
    clr_in(); roll = 0;
    chk("roll_flag", 32'(bus.RS_flag), 0);
    chk("roll_full", 32'(bus.RS_full), 0);
    bus.ALU_flag = 1; bus.ALU_ROB_idx = 11; bus.ALU_val = 32'h9;
    tick();
    clr_in();
    chk("roll_no_issue0", 32'(bus.RS_flag), 0);
    tick();
    chk("roll_no_issue1", 32'(bus.RS_flag), 0);

    // Stall with rdy low while an issue is on the bus and another entry is ready.
    clr_in(); put_dsp(OP_ADD, 1, 2, 0, 0, 0, 0, 4'd10); tick();
    clr_in(); put_dsp(OP_ADD, 3, 4, 0, 0, 0, 0, 4'd11); tick();
    clr_in();
    chk("rdy_a_flag", 32'(bus.RS_flag), 1);
    chk("rdy_a_idx",  32'(bus.RS_idx), 10);
    rdy = 0;
    for (int k = 0; k < 4; k++) begin
      bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'(k); bus.ALU_val = 32'(k);
      tick();
      chk("rdy_hold_flag", 32'(bus.RS_flag), 1);
      chk("rdy_hold_idx",  32'(bus.RS_idx), 10);
    end
    clr_in(); rdy = 1; tick();
    chk("rdy_b_flag", 32'(bus.RS_flag), 1);
    chk("rdy_b_idx",  32'(bus.RS_idx), 11);
    chk("rdy_b_vj",   bus.RS_Vj, 3);
    tick();
    chk("rdy_end", 32'(bus.RS_flag), 0);

    for (int c = 0; c < 600; c++) begin
      clr_in();
      rdy  = ($urandom_range(9) != 0);
      roll = ($urandom_range(63) == 0);
      if (m_count() < N && $urandom_range(1) == 1)
        put_dsp(6'($urandom_range(63)), $urandom, $urandom, 1'($urandom_range(1)),
                4'($urandom_range(7)), 1'($urandom_range(1)), 4'($urandom_range(7)),
                4'($urandom_range(15)));
      if ($urandom_range(2) == 0) begin
        bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'($urandom_range(7)); bus.ALU_val = $urandom;
      end
      if ($urandom_range(2) == 0) begin
        bus.LSB_flag = 1; bus.LSB_ROB_idx = 4'($urandom_range(7)); bus.LSB_val = $urandom;
      end
      tick();
    end
    roll = 0;

    // Reset must act even while rdy is low.
    clr_in(); rdy = 0; rst = 1; tick();
    chk("rst_rdy0_flag", 32'(bus.RS_flag), 0);
    chk("rst_rdy0_full", 32'(bus.RS_full), 0);
    chk("rst_rdy0_vj",   bus.RS_Vj, 0);
    rst = 0; rdy = 1; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
